mdu_iter: RTL and testbench



---
 rtl/mdu_iter.sv | 199 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO.
//             One operation per start pulse. Busy is held for MUL_CYCLES or
//             DIV_CYCLES. A one-cycle done pulse follows the HI/LO write.
//             Cancel aborts an in-flight operation without writing HI/LO.
//  Options  : MDU_MADD_EN - when defined, op 6 (MADD) and op 7 (MSUB)
//             accumulate into {HI,LO}. Otherwise these ops are no-ops.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  // Result datapath works on the latched operands; it is only consumed on the
  // final RUN edge, so its long combinational path has the whole RUN window.
  logic [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0] uprod;
  logic               sdiv;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   div_n;
  logic [WIDTH-1:0]   div_d;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign sprod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign uprod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed divide reuses the unsigned divider on magnitudes. The overflow case
  // (-2^(W-1) / -1) falls out naturally: magnitude 2^(W-1) re-reads as -2^(W-1).
  assign sdiv     = (op_q == OP_DIV);
  assign a_neg    = sdiv & a_q[WIDTH-1];
  assign b_neg    = sdiv & b_q[WIDTH-1];
  assign div_n    = a_neg ? -a_q : a_q;
  assign div_d    = b_neg ? -b_q : b_q;
  assign quot_mag = div_n / div_d;
  assign rem_mag  = div_n % div_d;
  assign quot     = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
  assign rem      = a_neg ? -rem_mag : rem_mag;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_add;
  logic [2*WIDTH-1:0] acc_sub;
  assign acc_add = {hi_q, lo_q} + sprod;
  assign acc_sub = {hi_q, lo_q} - sprod;
`endif

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
`ifdef MDU_MADD_EN
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
            OP_MULT, OP_MULTU: begin
`endif
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = MUL_LOAD;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = DIV_LOAD;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            case (op_q)
              OP_MULT:  {hi_d, lo_d} = sprod;
              OP_MULTU: {hi_d, lo_d} = uprod;
              OP_DIV, OP_DIVU: begin
                // Divide by zero runs full latency but leaves HI/LO intact.
                if (b_q != '0) begin
                  hi_d = rem;
                  lo_d = quot;
                end
              end
`ifdef MDU_MADD_EN
              OP_MADD:  {hi_d, lo_d} = acc_add;
              OP_MSUB:  {hi_d, lo_d} = acc_sub;
`endif
              default: ;
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter (WIDTH=32). Expected HI/LO and
//             latency come from a 64-bit arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  localparam int W   = 32;
  localparam int MUL = 5;
  localparam int DIV = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;

  mdu_iter #(
    .WIDTH      (W),
    .MUL_CYCLES (MUL),
    .DIV_CYCLES (DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Architectural reference: new {HI,LO} and busy length (0 = single-cycle/no-op).
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] h0, input logic [W-1:0] l0,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output int n);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(av);
    sb = $signed(bv);
    eh = h0;
    el = l0;
    n  = 0;
    case (o)
      3'd0: begin p = sa * sb; {eh, el} = p; n = MUL; end
      3'd1: begin p = {32'd0, av} * {32'd0, bv}; {eh, el} = p; n = MUL; end
      3'd2: begin
        n = DIV;
        if (bv != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      3'd3: begin
        n = DIV;
        if (bv != 0) begin el = av / bv; eh = av % bv; end
      end
      3'd4: eh = av;
      3'd5: el = av;
      default: begin
`ifdef MDU_MADD_EN
        p = sa * sb;
        if (o == 3'd6) p = {h0, l0} + p;
        else           p = {h0, l0} - p;
        {eh, el} = p;
        n = MUL;
`endif
      end
    endcase
  endtask

  // Issue one op at the current negedge and follow it cycle by cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int cancel_at, input bit extra_start);
    logic [W-1:0] eh, el;
    int n;
    model(o, av, bv, hi_m, lo_m, eh, el, n);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== eh || lo !== el) begin
        errors++;
        $display("FAIL single op=%0d busy=%b done=%b hi=%h lo=%h exp busy=0 done=0 hi=%h lo=%h",
                 o, busy, done, hi, lo, eh, el);
      end
      hi_m = eh; lo_m = el;
      return;
    end
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
        errors++;
        $display("FAIL run op=%0d cyc=%0d busy=%b done=%b hi=%h lo=%h exp busy=1 done=0 hi=%h lo=%h",
                 o, c, busy, done, hi, lo, hi_m, lo_m);
      end
      a = $urandom; b = $urandom;
      if (extra_start && c == 2) begin start = 1'b1; op = 3'd0; end
      if (c == cancel_at) cancel = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cancel = 1'b0;
      if (c == cancel_at) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
          errors++;
          $display("FAIL cancel op=%0d cyc=%0d busy=%b done=%b hi=%h lo=%h exp busy=0 done=0 hi=%h lo=%h",
                   o, c, busy, done, hi, lo, hi_m, lo_m);
        end
        return;
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL done op=%0d a=%h b=%h busy=%b done=%b hi=%h lo=%h exp busy=0 done=1 hi=%h lo=%h",
               o, av, bv, busy, done, hi, lo, eh, el);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
    end
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    run_op(3'd4, 32'hA5A5A5A5, 32'd0, 0, 1'b0);
    run_op(3'd5, 32'h5A5A5A5A, 32'd0, 0, 1'b0);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_const hi=%h lo=%h exp ffffffff fffffffa", hi, lo);
    end
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 1'b0);
    checks++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL multu_const hi=%h lo=%h exp 00000002 fffffffa", hi, lo);
    end
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_const hi=%h lo=%h exp ffffffff fffffffd", hi, lo);
    end
    run_op(3'd3, 32'd7, 32'd2, 0, 1'b0);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++; $display("FAIL divu_const hi=%h lo=%h exp 1 3", hi, lo);
    end
    run_op(3'd4, 32'h11, 32'd0, 0, 1'b0);
    run_op(3'd5, 32'h22, 32'd0, 0, 1'b0);
    run_op(3'd3, 32'd99, 32'd0, 0, 1'b0);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL divzero hi=%h lo=%h exp 11 22", hi, lo);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf hi=%h lo=%h exp 0 80000000", hi, lo);
    end
    run_op(3'd5, 32'h1234, 32'd0, 0, 1'b0);
    checks++;
    if (lo !== 32'h1234) begin
      errors++; $display("FAIL mtlo_const lo=%h exp 1234", lo);
    end
  endtask

  task automatic test_start_during_run;
    run_op(3'd2, 32'd1000, 32'd33, 0, 1'b1);
    run_op(3'd3, 32'hDEADBEEF, 32'h1234, 0, 1'b1);
  endtask

  task automatic test_cancel;
    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 3, 1'b0);
    run_op(3'd0, 32'h0BADF00D, 32'h00C0FFEE, MUL, 1'b0);
    run_op(3'd2, 32'hF0000000, 32'd3, DIV, 1'b0);
    // cancel in IDLE suppresses both multi-cycle and move ops
    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b1; op = 3'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
      errors++;
      $display("FAIL cancel_idle busy=%b done=%b hi=%h lo=%h exp busy=0 done=0 hi=%h lo=%h",
               busy, done, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_madd;
    run_op(3'd4, 32'd0, 32'd0, 0, 1'b0);
    run_op(3'd5, 32'd1, 32'd0, 0, 1'b0);
    run_op(3'd6, 32'd2, 32'd3, 0, 1'b0);
`ifdef MDU_MADD_EN
    checks++;
    if (hi !== 32'd0 || lo !== 32'd7) begin
      errors++; $display("FAIL madd_const hi=%h lo=%h exp 0 7", hi, lo);
    end
    run_op(3'd7, 32'd1, 32'd8, 0, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL msub_const hi=%h lo=%h exp ffffffff ffffffff", hi, lo);
    end
`else
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd1) begin
      errors++; $display("FAIL madd_noop busy=%b hi=%h lo=%h exp 0 0 1", busy, hi, lo);
    end
    run_op(3'd7, 32'd1, 32'd8, 0, 1'b0);
`endif
  endtask

  task automatic test_random;
    logic [2:0]   o;
    logic [W-1:0] av, bv;
    int           sel;
    for (int i = 0; i < 80; i++) begin
      o   = 3'($urandom_range(0, 7));
      av  = $urandom;
      bv  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) bv = '0;
      else if (sel == 1) begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
      else if (sel == 2) bv = 32'($urandom_range(1, 15));
      run_op(o, av, bv,
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, DIV) : 0,
             $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_back_to_back;
    // each run_op starts in the cycle the previous done is high
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    run_op(3'd2, 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 1'b0);
    run_op(3'd5, 32'h0F0F0F0F, 32'd0, 0, 1'b0);
    run_op(3'd3, 32'hFFFFFFFF, 32'd16, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_during_run();
    test_cancel();
    test_madd();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
